// File: rtl/pulp_io_pkg.sv
// ============================================================================
// Module      : pulp_io_pkg
// Description : Shared types for the pulp_io L2 port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulp_io_pkg;

    localparam int unsigned L2_ADDR_WIDTH = 32;
    localparam int unsigned L2_DATA_WIDTH = 32;
    localparam int unsigned PERF_CNT_W    = 16;

    typedef enum logic {
        L2_ID_RO = 1'b0,
        L2_ID_WO = 1'b1
    } l2_port_id_e;

    typedef struct packed {
        logic                       wen;
        logic [L2_ADDR_WIDTH-1:0]   addr;
        logic [L2_DATA_WIDTH/8-1:0] be;
        logic [L2_DATA_WIDTH-1:0]   wdata;
    } l2_req_t;

    function automatic l2_port_id_e other_port(input l2_port_id_e id);
        return (id == L2_ID_RO) ? L2_ID_WO : L2_ID_RO;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pulp_io_l2_id_fifo.sv
// ============================================================================
// Module      : pulp_io_l2_id_fifo
// Description : In-order FIFO of issuing-port IDs used to steer L2 responses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulp_io_l2_id_fifo
    import pulp_io_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  l2_port_id_e data_i,
    input  logic        pop_i,
    output logic        full_o,
    output logic        empty_o,
    output l2_port_id_e head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = l2_port_id_e'(mem_q[rd_ptr_q]);

    always_comb begin
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Simultaneous push and pop leave the occupancy unchanged.
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pulp_io_l2_port_arbiter.sv
// ============================================================================
// Module      : pulp_io_l2_port_arbiter
// Description : Merges the uDMA ro/wo L2 ports onto one L2 master port with
//               locked round-robin arbitration and in-order response routing.
//               Optional stall counters: define PULP_IO_L2_ARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulp_io_l2_port_arbiter
    import pulp_io_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = L2_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH      = L2_ADDR_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                    sys_clk_i,
    input  logic                    sys_rst_ni,

    input  logic                    ro_req_i,
    input  logic                    ro_wen_i,
    input  logic [ADDR_WIDTH-1:0]   ro_addr_i,
    input  logic [DATA_WIDTH/8-1:0] ro_be_i,
    input  logic [DATA_WIDTH-1:0]   ro_wdata_i,
    output logic                    ro_gnt_o,
    output logic                    ro_rvalid_o,
    output logic [DATA_WIDTH-1:0]   ro_rdata_o,

    input  logic                    wo_req_i,
    input  logic                    wo_wen_i,
    input  logic [ADDR_WIDTH-1:0]   wo_addr_i,
    input  logic [DATA_WIDTH/8-1:0] wo_be_i,
    input  logic [DATA_WIDTH-1:0]   wo_wdata_i,
    output logic                    wo_gnt_o,
    output logic                    wo_rvalid_o,
    output logic [DATA_WIDTH-1:0]   wo_rdata_o,

    output logic                    l2_req_o,
    output logic                    l2_wen_o,
    output logic [ADDR_WIDTH-1:0]   l2_addr_o,
    output logic [DATA_WIDTH/8-1:0] l2_be_o,
    output logic [DATA_WIDTH-1:0]   l2_wdata_o,
    input  logic                    l2_gnt_i,
    input  logic                    l2_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   l2_rdata_i,

`ifdef PULP_IO_L2_ARB_PERF_EN
    input  logic                    perf_clr_i,
    output logic [PERF_CNT_W-1:0]   ro_stall_cnt_o,
    output logic [PERF_CNT_W-1:0]   wo_stall_cnt_o,
`endif

    output logic                    err_o
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    typedef struct packed {
        logic                  wen;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BE_WIDTH-1:0]   be;
        logic [DATA_WIDTH-1:0] wdata;
    } req_bus_t;

    l2_port_id_e rr_q, rr_d;
    l2_port_id_e locked_id_q, locked_id_d;
    logic        lock_q, lock_d;
    logic        err_q, err_d;

    l2_port_id_e sel_id;
    logic        sel_req;
    logic        handshake;
    req_bus_t    ro_bus, wo_bus, sel_bus;

    logic        fifo_full;
    logic        fifo_empty;
    l2_port_id_e fifo_head;

    assign ro_bus = '{wen: ro_wen_i, addr: ro_addr_i, be: ro_be_i, wdata: ro_wdata_i};
    assign wo_bus = '{wen: wo_wen_i, addr: wo_addr_i, be: wo_be_i, wdata: wo_wdata_i};

    always_comb begin
        sel_id = rr_q;
        if (lock_q) begin
            sel_id = locked_id_q;
        end else if (ro_req_i && !wo_req_i) begin
            sel_id = L2_ID_RO;
        end else if (wo_req_i && !ro_req_i) begin
            sel_id = L2_ID_WO;
        end
        sel_req = (sel_id == L2_ID_WO) ? wo_req_i : ro_req_i;
        sel_bus = (sel_id == L2_ID_WO) ? wo_bus : ro_bus;
    end

    // A full FIFO blocks issue outright; a same-cycle pop does not bypass it.
    assign l2_req_o   = sel_req & ~fifo_full;
    assign handshake  = l2_req_o & l2_gnt_i;
    // Payload is zeroed while idle so the master port is quiet out of reset.
    assign l2_wen_o   = l2_req_o & sel_bus.wen;
    assign l2_addr_o  = l2_req_o ? sel_bus.addr  : '0;
    assign l2_be_o    = l2_req_o ? sel_bus.be    : '0;
    assign l2_wdata_o = l2_req_o ? sel_bus.wdata : '0;

    assign ro_gnt_o = handshake & (sel_id == L2_ID_RO);
    assign wo_gnt_o = handshake & (sel_id == L2_ID_WO);

    assign ro_rvalid_o = l2_rvalid_i & ~fifo_empty & (fifo_head == L2_ID_RO);
    assign wo_rvalid_o = l2_rvalid_i & ~fifo_empty & (fifo_head == L2_ID_WO);
    assign ro_rdata_o  = l2_rdata_i;
    assign wo_rdata_o  = l2_rdata_i;
    assign err_o       = err_q;

    always_comb begin
        rr_d        = rr_q;
        lock_d      = lock_q;
        locked_id_d = locked_id_q;
        err_d       = err_q | (l2_rvalid_i & fifo_empty);
        if (handshake) begin
            rr_d   = other_port(sel_id);
            lock_d = 1'b0;
        end else if (l2_req_o && !l2_gnt_i) begin
            lock_d      = 1'b1;
            locked_id_d = sel_id;
        end else if (lock_q && !sel_req) begin
            // Locked port withdrew its request: release rather than deadlock.
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            rr_q        <= L2_ID_RO;
            lock_q      <= 1'b0;
            locked_id_q <= L2_ID_RO;
            err_q       <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            lock_q      <= lock_d;
            locked_id_q <= locked_id_d;
            err_q       <= err_d;
        end
    end

    pulp_io_l2_id_fifo #(
        .DEPTH   (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (sys_clk_i),
        .rst_ni  (sys_rst_ni),
        .push_i  (handshake),
        .data_i  (sel_id),
        .pop_i   (l2_rvalid_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

`ifdef PULP_IO_L2_ARB_PERF_EN
    localparam logic [PERF_CNT_W-1:0] PERF_CNT_MAX = '1;

    logic [PERF_CNT_W-1:0] ro_stall_q, ro_stall_d;
    logic [PERF_CNT_W-1:0] wo_stall_q, wo_stall_d;

    always_comb begin
        ro_stall_d = ro_stall_q;
        wo_stall_d = wo_stall_q;
        if (perf_clr_i) begin
            ro_stall_d = '0;
            wo_stall_d = '0;
        end else begin
            if (ro_req_i && !ro_gnt_o && (ro_stall_q != PERF_CNT_MAX)) begin
                ro_stall_d = ro_stall_q + PERF_CNT_W'(1);
            end
            if (wo_req_i && !wo_gnt_o && (wo_stall_q != PERF_CNT_MAX)) begin
                wo_stall_d = wo_stall_q + PERF_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            ro_stall_q <= '0;
            wo_stall_q <= '0;
        end else begin
            ro_stall_q <= ro_stall_d;
            wo_stall_q <= wo_stall_d;
        end
    end

    assign ro_stall_cnt_o = ro_stall_q;
    assign wo_stall_cnt_o = wo_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pulp_io_l2_port_arbiter.sv
// ============================================================================
// Module      : tb_pulp_io_l2_port_arbiter
// Description : Self-checking bench for pulp_io_l2_port_arbiter (directed
//               scenarios plus randomized traffic against a queue model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulp_io_l2_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ro_req_i, ro_wen_i, wo_req_i, wo_wen_i;
    logic [AW-1:0] ro_addr_i, wo_addr_i;
    logic [BW-1:0] ro_be_i, wo_be_i;
    logic [DW-1:0] ro_wdata_i, wo_wdata_i;
    logic          ro_gnt_o, ro_rvalid_o, wo_gnt_o, wo_rvalid_o;
    logic [DW-1:0] ro_rdata_o, wo_rdata_o;
    logic          l2_req_o, l2_wen_o, l2_gnt_i, l2_rvalid_i;
    logic [AW-1:0] l2_addr_o;
    logic [BW-1:0] l2_be_o;
    logic [DW-1:0] l2_wdata_o, l2_rdata_i;
    logic          err_o;
`ifdef PULP_IO_L2_ARB_PERF_EN
    logic          perf_clr_i;
    logic [15:0]   ro_stall_cnt_o, wo_stall_cnt_o;
    int            m_ro_stall, m_wo_stall;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model: outstanding IDs in issue order plus arbitration state.
    bit mq[$];
    bit m_lock, m_lock_id, m_rr, m_err;
    bit e_sel, e_sel_req, e_req, e_ro_gnt, e_wo_gnt, e_ro_rv, e_wo_rv;

    always #5 clk = ~clk;

    pulp_io_l2_port_arbiter #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .sys_clk_i   (clk),
        .sys_rst_ni  (rst_n),
        .ro_req_i    (ro_req_i),
        .ro_wen_i    (ro_wen_i),
        .ro_addr_i   (ro_addr_i),
        .ro_be_i     (ro_be_i),
        .ro_wdata_i  (ro_wdata_i),
        .ro_gnt_o    (ro_gnt_o),
        .ro_rvalid_o (ro_rvalid_o),
        .ro_rdata_o  (ro_rdata_o),
        .wo_req_i    (wo_req_i),
        .wo_wen_i    (wo_wen_i),
        .wo_addr_i   (wo_addr_i),
        .wo_be_i     (wo_be_i),
        .wo_wdata_i  (wo_wdata_i),
        .wo_gnt_o    (wo_gnt_o),
        .wo_rvalid_o (wo_rvalid_o),
        .wo_rdata_o  (wo_rdata_o),
        .l2_req_o    (l2_req_o),
        .l2_wen_o    (l2_wen_o),
        .l2_addr_o   (l2_addr_o),
        .l2_be_o     (l2_be_o),
        .l2_wdata_o  (l2_wdata_o),
        .l2_gnt_i    (l2_gnt_i),
        .l2_rvalid_i (l2_rvalid_i),
        .l2_rdata_i  (l2_rdata_i),
`ifdef PULP_IO_L2_ARB_PERF_EN
        .perf_clr_i     (perf_clr_i),
        .ro_stall_cnt_o (ro_stall_cnt_o),
        .wo_stall_cnt_o (wo_stall_cnt_o),
`endif
        .err_o       (err_o)
    );

    task automatic clear_inputs();
        ro_req_i = 0; ro_wen_i = 0; ro_addr_i = '0; ro_be_i = '0; ro_wdata_i = '0;
        wo_req_i = 0; wo_wen_i = 0; wo_addr_i = '0; wo_be_i = '0; wo_wdata_i = '0;
        l2_gnt_i = 0; l2_rvalid_i = 0; l2_rdata_i = '0;
`ifdef PULP_IO_L2_ARB_PERF_EN
        perf_clr_i = 0;
`endif
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        mq.delete();
        m_lock = 0; m_lock_id = 0; m_rr = 0; m_err = 0;
`ifdef PULP_IO_L2_ARB_PERF_EN
        m_ro_stall = 0; m_wo_stall = 0;
`endif
    endtask

    // Waits to the sampling edge and derives expected outputs from the model.
    task automatic settle();
        @(negedge clk);
        if (m_lock)                      e_sel = m_lock_id;
        else if (ro_req_i && !wo_req_i)  e_sel = 0;
        else if (wo_req_i && !ro_req_i)  e_sel = 1;
        else                             e_sel = m_rr;
        e_sel_req = e_sel ? wo_req_i : ro_req_i;
        e_req     = e_sel_req && (mq.size() < MO);
        e_ro_gnt  = e_req && l2_gnt_i && !e_sel;
        e_wo_gnt  = e_req && l2_gnt_i && e_sel;
        e_ro_rv   = l2_rvalid_i && (mq.size() > 0) && (mq[0] == 1'b0);
        e_wo_rv   = l2_rvalid_i && (mq.size() > 0) && (mq[0] == 1'b1);
    endtask

    // Advances the model across the active edge, then steps off it.
    task automatic tick();
        bit hs;
        @(posedge clk);
        hs = e_req && l2_gnt_i;
        if (l2_rvalid_i) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else m_err = 1;
        end
        if (hs) mq.push_back(e_sel);
        if (hs) begin
            m_lock = 0;
            m_rr   = !e_sel;
        end else if (e_req) begin
            m_lock = 1;
            m_lock_id = e_sel;
        end else if (m_lock && !e_sel_req) begin
            m_lock = 0;
        end
`ifdef PULP_IO_L2_ARB_PERF_EN
        if (perf_clr_i) begin
            m_ro_stall = 0; m_wo_stall = 0;
        end else begin
            if (ro_req_i && !e_ro_gnt && m_ro_stall < 65535) m_ro_stall++;
            if (wo_req_i && !e_wo_gnt && m_wo_stall < 65535) m_wo_stall++;
        end
`endif
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        #2;
        chk_cnt++;
        if ({l2_req_o, ro_gnt_o, wo_gnt_o, ro_rvalid_o, wo_rvalid_o, err_o, l2_addr_o} !== '0)
            $display("FAIL reset_outputs: got req=%b rg=%b wg=%b rrv=%b wrv=%b err=%b addr=%h, want all 0",
                     l2_req_o, ro_gnt_o, wo_gnt_o, ro_rvalid_o, wo_rvalid_o, err_o, l2_addr_o);
        else pass_cnt++;
        apply_reset();
        // Both request right after reset: ro must win first.
        ro_req_i = 1; wo_req_i = 1; ro_addr_i = 32'h100; wo_addr_i = 32'h200;
        settle();
        chk_cnt++;
        if (l2_addr_o !== 32'h100 || l2_req_o !== 1'b1)
            $display("FAIL reset_rr_priority: got req=%b addr=%h, want req=1 addr=00000100", l2_req_o, l2_addr_o);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_single_ro_read();
        apply_reset();
        ro_req_i = 1; ro_wen_i = 1; ro_addr_i = 32'h1C00_0000; ro_be_i = 4'hF; l2_gnt_i = 1;
        settle();
        chk_cnt++;
        if (ro_gnt_o !== 1'b1 || wo_gnt_o !== 1'b0 || l2_addr_o !== 32'h1C00_0000 || l2_wen_o !== 1'b1)
            $display("FAIL single_ro_grant: got rg=%b wg=%b addr=%h wen=%b, want rg=1 wg=0 addr=1c000000 wen=1",
                     ro_gnt_o, wo_gnt_o, l2_addr_o, l2_wen_o);
        else pass_cnt++;
        tick();
        ro_req_i = 0; l2_gnt_i = 0; l2_rvalid_i = 1; l2_rdata_i = 32'hDEAD_BEEF;
        settle();
        chk_cnt++;
        if (ro_rvalid_o !== 1'b1 || wo_rvalid_o !== 1'b0 || ro_rdata_o !== 32'hDEAD_BEEF)
            $display("FAIL single_ro_rvalid: got rrv=%b wrv=%b rdata=%h, want rrv=1 wrv=0 rdata=deadbeef",
                     ro_rvalid_o, wo_rvalid_o, ro_rdata_o);
        else pass_cnt++;
        tick();
        l2_rvalid_i = 0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        ro_addr_i = 32'hA0; wo_addr_i = 32'hB0; wo_wen_i = 0; ro_wen_i = 1;
        for (int k = 0; k < 8; k++) begin
            ro_req_i = (k < 6); wo_req_i = (k < 6); l2_gnt_i = 1;
            l2_rvalid_i = (k >= 2); l2_rdata_i = 32'h5000 + k;
            settle();
            chk_cnt++;
            if (ro_gnt_o !== (k < 6 && k % 2 == 0) || wo_gnt_o !== (k < 6 && k % 2 == 1))
                $display("FAIL alt_grant[%0d]: got rg=%b wg=%b, want rg=%b wg=%b", k, ro_gnt_o, wo_gnt_o,
                         (k < 6 && k % 2 == 0), (k < 6 && k % 2 == 1));
            else pass_cnt++;
            chk_cnt++;
            if (ro_rvalid_o !== (k >= 2 && k % 2 == 0) || wo_rvalid_o !== (k >= 2 && k % 2 == 1))
                $display("FAIL alt_rvalid[%0d]: got rrv=%b wrv=%b, want rrv=%b wrv=%b", k, ro_rvalid_o,
                         wo_rvalid_o, (k >= 2 && k % 2 == 0), (k >= 2 && k % 2 == 1));
            else pass_cnt++;
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_lock();
        apply_reset();
        wo_req_i = 1; wo_addr_i = 32'h1C00_1000; ro_addr_i = 32'h1C00_2000; l2_gnt_i = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) ro_req_i = 1;
            if (c == 3) l2_gnt_i = 1;
            settle();
            chk_cnt++;
            if (l2_addr_o !== 32'h1C00_1000 || wo_gnt_o !== (c == 3) || ro_gnt_o !== 1'b0)
                $display("FAIL lock_hold[%0d]: got addr=%h wg=%b rg=%b, want addr=1c001000 wg=%b rg=0",
                         c, l2_addr_o, wo_gnt_o, ro_gnt_o, (c == 3));
            else pass_cnt++;
            tick();
        end
        wo_req_i = 0;
        settle();
        chk_cnt++;
        if (ro_gnt_o !== 1'b1 || l2_addr_o !== 32'h1C00_2000)
            $display("FAIL lock_next_ro: got rg=%b addr=%h, want rg=1 addr=1c002000", ro_gnt_o, l2_addr_o);
        else pass_cnt++;
        tick();
        clear_inputs();
    endtask

    task automatic test_fifo_full();
        apply_reset();
        ro_req_i = 1; ro_wen_i = 1; l2_gnt_i = 1;
        for (int c = 0; c < 7; c++) begin
            l2_rvalid_i = (c == 5);
            settle();
            chk_cnt++;
            if (l2_req_o !== (c < 4 || c == 6) || ro_gnt_o !== (c < 4 || c == 6))
                $display("FAIL full_gate[%0d]: got req=%b rg=%b, want %b", c, l2_req_o, ro_gnt_o, (c < 4 || c == 6));
            else pass_cnt++;
            if (c == 5) begin
                chk_cnt++;
                if (ro_rvalid_o !== 1'b1)
                    $display("FAIL full_pop_rvalid: got rrv=%b, want 1", ro_rvalid_o);
                else pass_cnt++;
            end
            tick();
        end
        ro_req_i = 0; l2_rvalid_i = 1;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk_cnt++;
            if (ro_rvalid_o !== 1'b1)
                $display("FAIL full_drain[%0d]: got rrv=%b, want 1", c, ro_rvalid_o);
            else pass_cnt++;
            tick();
        end
        l2_rvalid_i = 0;
        settle();
        chk_cnt++;
        if (err_o !== 1'b0)
            $display("FAIL full_no_err: got err=%b, want 0", err_o);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_err();
        apply_reset();
        l2_rvalid_i = 1;
        settle();
        chk_cnt++;
        if (ro_rvalid_o !== 1'b0 || wo_rvalid_o !== 1'b0)
            $display("FAIL err_no_rvalid: got rrv=%b wrv=%b, want 0 0", ro_rvalid_o, wo_rvalid_o);
        else pass_cnt++;
        tick();
        l2_rvalid_i = 0;
        repeat (3) begin settle(); tick(); end
        settle();
        chk_cnt++;
        if (err_o !== 1'b1)
            $display("FAIL err_sticky: got err=%b, want 1", err_o);
        else pass_cnt++;
        rst_n = 0;
        #1;
        chk_cnt++;
        if (err_o !== 1'b0)
            $display("FAIL err_reset_clear: got err=%b, want 0", err_o);
        else pass_cnt++;
        apply_reset();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            ro_req_i = ($urandom % 4) != 0;  wo_req_i = ($urandom % 4) != 0;
            ro_wen_i = $urandom;  wo_wen_i = $urandom;
            ro_addr_i = $urandom; wo_addr_i = $urandom;
            ro_be_i = $urandom;   wo_be_i = $urandom;
            ro_wdata_i = $urandom; wo_wdata_i = $urandom;
            l2_gnt_i = ($urandom % 3) != 0;
            l2_rvalid_i = (mq.size() > 0) ? (($urandom % 2) == 1) : (($urandom % 80) == 0);
            l2_rdata_i = $urandom;
`ifdef PULP_IO_L2_ARB_PERF_EN
            perf_clr_i = ($urandom % 64) == 0;
`endif
            settle();
            chk_cnt++;
            if (l2_req_o !== e_req || ro_gnt_o !== e_ro_gnt || wo_gnt_o !== e_wo_gnt)
                $display("FAIL rand_req[%0d]: got req=%b rg=%b wg=%b, want req=%b rg=%b wg=%b",
                         c, l2_req_o, ro_gnt_o, wo_gnt_o, e_req, e_ro_gnt, e_wo_gnt);
            else pass_cnt++;
            chk_cnt++;
            if (ro_rvalid_o !== e_ro_rv || wo_rvalid_o !== e_wo_rv)
                $display("FAIL rand_rvalid[%0d]: got rrv=%b wrv=%b, want rrv=%b wrv=%b",
                         c, ro_rvalid_o, wo_rvalid_o, e_ro_rv, e_wo_rv);
            else pass_cnt++;
            if (e_ro_rv || e_wo_rv) begin
                chk_cnt++;
                if ((e_ro_rv ? ro_rdata_o : wo_rdata_o) !== l2_rdata_i)
                    $display("FAIL rand_rdata[%0d]: got %h, want %h", c,
                             (e_ro_rv ? ro_rdata_o : wo_rdata_o), l2_rdata_i);
                else pass_cnt++;
            end
            if (e_req) begin
                chk_cnt++;
                if (l2_addr_o !== (e_sel ? wo_addr_i : ro_addr_i) || l2_wen_o !== (e_sel ? wo_wen_i : ro_wen_i) ||
                    l2_be_o !== (e_sel ? wo_be_i : ro_be_i) || l2_wdata_o !== (e_sel ? wo_wdata_i : ro_wdata_i))
                    $display("FAIL rand_payload[%0d]: got addr=%h wen=%b be=%h wdata=%h from port %0d",
                             c, l2_addr_o, l2_wen_o, l2_be_o, l2_wdata_o, e_sel);
                else pass_cnt++;
            end
            chk_cnt++;
            if (err_o !== m_err)
                $display("FAIL rand_err[%0d]: got %b, want %b", c, err_o, m_err);
            else pass_cnt++;
`ifdef PULP_IO_L2_ARB_PERF_EN
            chk_cnt++;
            if (ro_stall_cnt_o !== 16'(m_ro_stall) || wo_stall_cnt_o !== 16'(m_wo_stall))
                $display("FAIL rand_stall[%0d]: got ro=%0d wo=%0d, want ro=%0d wo=%0d",
                         c, ro_stall_cnt_o, wo_stall_cnt_o, m_ro_stall, m_wo_stall);
            else pass_cnt++;
`endif
            tick();
        end
        clear_inputs();
    endtask

`ifdef PULP_IO_L2_ARB_PERF_EN
    task automatic test_perf();
        apply_reset();
        wo_req_i = 1; l2_gnt_i = 0;
        repeat (5) begin settle(); tick(); end
        wo_req_i = 0;
        settle();
        chk_cnt++;
        if (wo_stall_cnt_o !== 16'd5 || ro_stall_cnt_o !== 16'd0)
            $display("FAIL perf_count: got wo=%0d ro=%0d, want wo=5 ro=0", wo_stall_cnt_o, ro_stall_cnt_o);
        else pass_cnt++;
        tick();
        wo_req_i = 1; perf_clr_i = 1;
        settle(); tick();
        wo_req_i = 0; perf_clr_i = 0;
        settle();
        chk_cnt++;
        if (wo_stall_cnt_o !== 16'd0)
            $display("FAIL perf_clear: got wo=%0d, want 0", wo_stall_cnt_o);
        else pass_cnt++;
        tick();
        wo_req_i = 1;
        repeat (65540) @(posedge clk);
        #1;
        chk_cnt++;
        if (wo_stall_cnt_o !== 16'hFFFF)
            $display("FAIL perf_saturate: got %h, want ffff", wo_stall_cnt_o);
        else pass_cnt++;
        apply_reset();
    endtask
`endif

    initial begin
        clear_inputs();
        rst_n = 0;
        test_reset();
        test_single_ro_read();
        test_back_to_back();
        test_lock();
        test_fifo_full();
        test_err();
        test_random();
`ifdef PULP_IO_L2_ARB_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire
